text_mode_renderer: RTL and testbench



---
 rtl/text_mode_pkg.sv | 47 ++++
 rtl/text_raster_timing.sv | 77 +++++++
 rtl/text_mode_renderer.sv | 154 +++++++++++++++
 tb/tb_text_mode_renderer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_mode_pkg.sv
// Shared constants and types for the 80x25 character-cell renderer.
package text_mode_pkg;

    // Default 640x400 raster geometry
    localparam int unsigned H_VIS_DEF = 640;
    localparam int unsigned H_TOT_DEF = 800;
    localparam int unsigned V_VIS_DEF = 400;
    localparam int unsigned V_TOT_DEF = 449;

    // Porch and sync widths, measured from the end of the visible area
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_FP   = 12;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 35;

    // Sync window bounds for the default geometry
    localparam int unsigned HS_START_DEF = H_VIS_DEF + H_FP;
    localparam int unsigned HS_END_DEF   = H_VIS_DEF + H_FP + H_SYNC;
    localparam int unsigned VS_START_DEF = V_VIS_DEF + V_FP;
    localparam int unsigned VS_END_DEF   = V_VIS_DEF + V_FP + V_SYNC;

    // Character grid
    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 25;
    localparam int unsigned CELL_W = 8;
    localparam int unsigned CELL_H = 16;

    // Counter widths
    localparam int unsigned H_W     = 10;
    localparam int unsigned V_W     = 9;
    localparam int unsigned FRAME_W = 5;

    // Attribute byte fields
    localparam int unsigned ATTR_BLINK = 7;
    localparam int unsigned ATTR_BG_HI = 6;
    localparam int unsigned ATTR_BG_LO = 4;
    localparam int unsigned ATTR_FG_HI = 3;
    localparam int unsigned ATTR_FG_LO = 0;

    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] chr;
    } text_word_t;

endpackage

// File: rtl/text_raster_timing.sv
// Raster counters, sync/enable generation and next-line lookahead for the fetcher.
module text_raster_timing
    import text_mode_pkg::*;
#(
    parameter int unsigned H_VIS = H_VIS_DEF,
    parameter int unsigned H_TOT = H_TOT_DEF,
    parameter int unsigned V_VIS = V_VIS_DEF,
    parameter int unsigned V_TOT = V_TOT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic [H_W-1:0]     h,
    output logic [FRAME_W-1:0] frame,
    output logic [V_W-1:0]     line_ahead,
    output logic               visible,
    output logic               hsync_raw,
    output logic               vsync_raw,
    output logic               primed
);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOT - 1);
    localparam logic [H_W-1:0] H_PRIME  = H_W'(H_TOT - 3);
    localparam logic [H_W-1:0] H_AHEAD  = H_W'(H_TOT - CELL_W);
    localparam logic [H_W-1:0] H_VIS_L  = H_W'(H_VIS);
    localparam logic [H_W-1:0] HS_START = H_W'(H_VIS + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOT - 1);
    localparam logic [V_W-1:0] V_VIS_L  = V_W'(V_VIS);
    localparam logic [V_W-1:0] VS_START = V_W'(V_VIS + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_VIS + V_FP + V_SYNC);

    logic [H_W-1:0]     h_q;
    logic [V_W-1:0]     v_q;
    logic [FRAME_W-1:0] frame_q;
    logic               primed_q;
    logic [V_W-1:0]     v_next;

    // Advance h/v/frame on each pixel tick; primed marks the first full column-0 prefetch
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q      <= '0;
            v_q      <= '0;
            frame_q  <= '0;
            primed_q <= 1'b0;
        end else if (pix_ce) begin
            if (h_q == H_LAST) begin
                h_q <= '0;
                if (v_q == V_LAST) begin
                    v_q     <= '0;
                    frame_q <= frame_q + FRAME_W'(1);
                end else begin
                    v_q <= v_q + V_W'(1);
                end
            end else begin
                h_q <= h_q + H_W'(1);
            end
            if (h_q == H_PRIME && v_q == V_LAST) begin
                primed_q <= 1'b1;
            end
        end
    end

    // Near the end of a line the fetcher works on the following line
    always_comb begin
        v_next     = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
        line_ahead = (h_q >= H_AHEAD) ? v_next : v_q;
        visible    = (h_q < H_VIS_L) && (v_q < V_VIS_L);
        hsync_raw  = !((h_q >= HS_START) && (h_q < HS_END));
        vsync_raw  = (v_q >= VS_START) && (v_q < VS_END);
    end

    assign h      = h_q;
    assign frame  = frame_q;
    assign primed = primed_q;

endmodule

// File: rtl/text_mode_renderer.sv
// Text-mode renderer: cell fetch pipeline (text RAM -> font ROM) and pixel shifter.
module text_mode_renderer
    import text_mode_pkg::*;
#(
    parameter int unsigned H_VIS     = H_VIS_DEF,
    parameter int unsigned H_TOT     = H_TOT_DEF,
    parameter int unsigned V_VIS     = V_VIS_DEF,
    parameter int unsigned V_TOT     = V_TOT_DEF,
    parameter int unsigned BLINK_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic [10:0] text_addr,
    input  logic [15:0] text_q,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_q,
    output logic [3:0]  color,
    output logic        de,
    output logic        hsync,
    output logic        vsync
);

    localparam int unsigned COL_W    = H_W - 3;
    localparam int unsigned CELLS    = H_TOT / CELL_W;
    localparam int unsigned VIS_COLS = H_VIS / CELL_W;

    logic [H_W-1:0]     h;
    logic [FRAME_W-1:0] frame;
    logic [V_W-1:0]     line_ahead;
    logic               visible;
    logic               hsync_raw;
    logic               vsync_raw;
    logic               primed;

    text_raster_timing #(
        .H_VIS (H_VIS),
        .H_TOT (H_TOT),
        .V_VIS (V_VIS),
        .V_TOT (V_TOT)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .h          (h),
        .frame      (frame),
        .line_ahead (line_ahead),
        .visible    (visible),
        .hsync_raw  (hsync_raw),
        .vsync_raw  (vsync_raw),
        .primed     (primed)
    );

    text_word_t word;
    assign word = text_q;

    logic [2:0]       phase;
    logic [COL_W-1:0] col_raw;
    logic [COL_W-1:0] col;
    logic             target_ok;
    logic [10:0]      fetch_addr;

    logic [3:0] glyph_row_q;
    logic       pending_q;
    logic [7:0] attr_q;
    logic [7:0] hold_glyph_q;
    logic [7:0] hold_attr_q;
    logic [7:0] shift_q;
    logic [7:0] cur_attr_q;

    logic [7:0] src_glyph;
    logic [7:0] src_attr;
    logic [7:0] attr_now;
    logic       bit_now;
    logic       blink;
    logic [3:0] pix_color;

    // Target cell is three pixels ahead; the column index wraps at the end of the line
    always_comb begin
        phase      = h[2:0];
        col_raw    = h[H_W-1:3] + ((h[2:0] >= 3'd5) ? COL_W'(1) : COL_W'(0));
        col        = (col_raw >= COL_W'(CELLS)) ? col_raw - COL_W'(CELLS) : col_raw;
        target_ok  = (col < COL_W'(VIS_COLS)) && (line_ahead < V_W'(V_VIS));
        fetch_addr = 11'(line_ahead[V_W-1:4]) * 11'(COLS) + 11'(col);
    end

    // Pixel colour; on a cell boundary the bit comes straight from the holding registers
    always_comb begin
        src_glyph = pending_q ? hold_glyph_q : 8'h00;
        src_attr  = pending_q ? hold_attr_q : 8'h00;
        if (phase == 3'd0) begin
            bit_now  = src_glyph[7];
            attr_now = src_attr;
        end else begin
            bit_now  = shift_q[7];
            attr_now = cur_attr_q;
        end
        blink     = attr_now[ATTR_BLINK] & frame[BLINK_BIT];
        pix_color = 4'h0;
        if (visible && primed) begin
            pix_color = (bit_now && !blink) ? attr_now[ATTR_FG_HI:ATTR_FG_LO]
                                            : {1'b0, attr_now[ATTR_BG_HI:ATTR_BG_LO]};
        end
    end

    // Fetch pipeline, shifter and registered video outputs, all stepped by pix_ce
    always_ff @(posedge clk) begin
        if (reset) begin
            text_addr    <= '0;
            font_addr    <= '0;
            glyph_row_q  <= '0;
            pending_q    <= 1'b0;
            attr_q       <= '0;
            hold_glyph_q <= '0;
            hold_attr_q  <= '0;
            shift_q      <= '0;
            cur_attr_q   <= '0;
            color        <= '0;
            de           <= 1'b0;
            hsync        <= 1'b1;
            vsync        <= 1'b0;
        end else if (pix_ce) begin
            case (phase)
                3'd5: begin
                    if (target_ok) begin
                        text_addr <= fetch_addr;
                    end
                    pending_q   <= target_ok;
                    glyph_row_q <= line_ahead[3:0];
                end
                3'd6: begin
                    attr_q    <= word.attr;
                    font_addr <= {word.chr, glyph_row_q};
                end
                3'd7: begin
                    hold_glyph_q <= font_q;
                    hold_attr_q  <= attr_q;
                end
                default: ;
            endcase
            if (phase == 3'd0) begin
                shift_q    <= {src_glyph[6:0], 1'b0};
                cur_attr_q <= src_attr;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
            color <= pix_color;
            de    <= visible & primed;
            hsync <= hsync_raw;
            vsync <= vsync_raw;
        end
    end

endmodule

// File: tb/tb_text_mode_renderer.sv
// Directed bench for text_mode_renderer on a shrunken raster (64x32 visible, 184x47 total).
module tb_text_mode_renderer;

    localparam int HV  = 64;
    localparam int HT  = 184;
    localparam int VV  = 32;
    localparam int VT  = 47;
    localparam int HS0 = HV + 16;
    localparam int HS1 = HV + 16 + 96;
    localparam int VS0 = VV + 12;
    localparam int VS1 = VV + 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic [10:0] text_addr;
    logic [15:0] text_q;
    logic [11:0] font_addr;
    logic [7:0]  font_q;
    logic [3:0]  color;
    logic        de;
    logic        hsync;
    logic        vsync;

    text_mode_renderer #(
        .H_VIS     (HV),
        .H_TOT     (HT),
        .V_VIS     (VV),
        .V_TOT     (VT),
        .BLINK_BIT (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_ce    (pix_ce),
        .text_addr (text_addr),
        .text_q    (text_q),
        .font_addr (font_addr),
        .font_q    (font_q),
        .color     (color),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync)
    );

    always #5 clk = ~clk;

    // Memory models with one-clock registered reads
    logic [15:0] text_ram [0:2047];
    logic [7:0]  font_rom [0:4095];
    always @(posedge clk) begin
        text_q <= text_ram[text_addr];
        font_q <= font_rom[font_addr];
    end

    initial begin
        pix_ce = 1'b0;
        forever @(negedge clk) pix_ce = ~pix_ce;
    end

    // Raster position model: out_* is the position the current outputs represent
    int tb_h = 0, tb_v = 0, tb_fr = 0;
    int out_h = 0, out_v = 0, out_fr = 0;
    bit out_valid = 0, fresh = 0, rst_seen = 0;
    always @(posedge clk) begin
        rst_seen <= reset;
        fresh    <= pix_ce && !reset;
        if (reset) begin
            tb_h <= 0; tb_v <= 0; tb_fr <= 0; out_valid <= 0;
        end else if (pix_ce) begin
            out_h <= tb_h; out_v <= tb_v; out_fr <= tb_fr; out_valid <= 1;
            if (tb_h == HT - 1) begin
                tb_h <= 0;
                if (tb_v == VT - 1) begin
                    tb_v <= 0; tb_fr <= tb_fr + 1;
                end else begin
                    tb_v <= tb_v + 1;
                end
            end else begin
                tb_h <= tb_h + 1;
            end
        end
    end

    function automatic bit exp_hs(int h);
        return !(h >= HS0 && h < HS1);
    endfunction
    function automatic bit exp_vs(int v);
        return (v >= VS0 && v < VS1);
    endfunction
    // Row 0 is only trustworthy after a full frame since reset
    function automatic bit exp_de(int h, int v, int fr);
        return (fr != 0) && (h < HV) && (v < VV);
    endfunction

    int st_de [4] = '{default: 0};
    int st_hs [4] = '{default: 0};
    int st_vs [4] = '{default: 0};
    int run_hs = 0, run_de = 0, run_bad = 0;
    logic [6:0] last_out = '0;
    bit have_last = 0;

    always @(negedge clk) begin
        if (rst_seen) begin
            last_out  <= {color, de, hsync, vsync};
            have_last <= 1;
        end else if (fresh && out_valid) begin
            if (hsync != exp_hs(out_h) || vsync != exp_vs(out_v) ||
                de != exp_de(out_h, out_v, out_fr) || (!de && color != 4'h0))
                run_bad <= run_bad + 1;
            if (!hsync) run_hs <= run_hs + 1;
            if (de) run_de <= run_de + 1;
            if (out_fr < 4) begin
                if (de) st_de[out_fr] <= st_de[out_fr] + 1;
                if (!hsync) st_hs[out_fr] <= st_hs[out_fr] + 1;
                if (vsync) st_vs[out_fr] <= st_vs[out_fr] + 1;
            end
            last_out <= {color, de, hsync, vsync};
        end else if (have_last && last_out != {color, de, hsync, vsync}) begin
            run_bad <= run_bad + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    task automatic wait_pos(input int fr, input int v, input int h, output bit ok);
        ok = 0;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (out_valid && fresh && out_fr == fr && out_v == v && out_h == h) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        int fr;
        int v;
        int h;
        int color;
        int de;
        int font;
    } vec_t;

    vec_t vecs [20];

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        bit ok;
        int hs0, de0, bad0;

        vecs[0]  = '{0, 0, 0, 0, 0, -1};     // just after reset: not primed
        vecs[1]  = '{0, 10, 5, 0, 0, -1};
        vecs[2]  = '{1, 0, 0, 1, 1, -1};     // glyph 0x18, attr 0x1F
        vecs[3]  = '{1, 0, 3, 15, 1, -1};
        vecs[4]  = '{1, 0, 4, 15, 1, -1};
        vecs[5]  = '{1, 0, 5, 1, 1, -1};
        vecs[6]  = '{1, 0, 7, 1, 1, -1};
        vecs[7]  = '{1, 0, 24, 0, 1, -1};    // blink cell, blink phase on
        vecs[8]  = '{1, 0, 56, 7, 1, -1};    // last visible column
        vecs[9]  = '{1, 0, 63, 7, 1, -1};
        vecs[10] = '{1, 0, 64, 0, 0, -1};    // first blank pixel
        vecs[11] = '{1, 15, 56, 7, 1, -1};
        vecs[12] = '{1, 16, 56, 0, 1, -1};
        vecs[13] = '{1, 26, 0, 7, 1, 'h02A}; // row 1, glyph row 10
        vecs[14] = '{1, 26, 1, 0, 1, -1};
        vecs[15] = '{1, 26, 7, 7, 1, -1};
        vecs[16] = '{1, 32, 0, 0, 0, -1};    // first non-visible line
        vecs[17] = '{2, 0, 0, 1, 1, -1};
        vecs[18] = '{2, 0, 24, 15, 1, -1};   // blink phase off
        vecs[19] = '{2, 0, 31, 15, 1, -1};

        for (int i = 0; i < 2048; i++) text_ram[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) font_rom[i] = 8'h00;
        text_ram[0]  = 16'h1F41;
        text_ram[3]  = 16'h8FDB;
        text_ram[7]  = 16'h0700;
        text_ram[80] = 16'h0702;
        font_rom['h410] = 8'h18;
        for (int r = 0; r < 16; r++) begin
            font_rom[r]         = 8'hFF;
            font_rom['hDB0 + r] = 8'hFF;
        end
        font_rom['h02A] = 8'h81;

        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_color", int'(color), 0);
        check("reset_de", int'(de), 0);
        check("reset_hsync", int'(hsync), 1);
        check("reset_vsync", int'(vsync), 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            wait_pos(vecs[i].fr, vecs[i].v, vecs[i].h, ok);
            check($sformatf("vec%0d_reached", i), int'(ok), 1);
            if (ok) begin
                check($sformatf("vec%0d_color", i), int'(color), vecs[i].color);
                check($sformatf("vec%0d_de", i), int'(de), vecs[i].de);
                if (vecs[i].font >= 0)
                    check($sformatf("vec%0d_font_addr", i), int'(font_addr), vecs[i].font);
            end
        end

        wait_pos(3, 0, 0, ok);
        check("frame3_reached", int'(ok), 1);
        check("f0_de_count", st_de[0], 0);
        check("f1_de_count", st_de[1], HV * VV);
        check("f2_de_count", st_de[2], HV * VV);
        check("f0_hsync_low", st_hs[0], 96 * VT);
        check("f1_hsync_low", st_hs[1], 96 * VT);
        check("f2_hsync_low", st_hs[2], 96 * VT);
        check("f1_vsync_high", st_vs[1], 2 * HT);
        check("f2_vsync_high", st_vs[2], 2 * HT);

        // Reset in the middle of the hsync pulse
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (tb_fr == 3 && tb_v == 5 && tb_h == 100) begin
                ok = 1;
                break;
            end
        end
        check("midreset_reached", int'(ok), 1);
        check("pre_reset_hsync", int'(hsync), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_color", int'(color), 0);
        check("mid_de", int'(de), 0);
        check("mid_hsync", int'(hsync), 1);
        check("mid_vsync", int'(vsync), 0);
        check("mid_text_addr", int'(text_addr), 0);
        check("mid_font_addr", int'(font_addr), 0);
        check("mid_h", int'(dut.u_timing.h_q), 0);
        check("mid_v", int'(dut.u_timing.v_q), 0);
        check("mid_frame", int'(dut.u_timing.frame_q), 0);
        hs0  = run_hs;
        de0  = run_de;
        bad0 = run_bad;
        repeat (4 * HT) @(negedge clk);
        check("post_hsync_low", run_hs - hs0, 2 * 96);
        check("post_de_count", run_de - de0, 0);
        check("post_raster_bad", run_bad - bad0, 0);
        check("post_v", int'(dut.u_timing.v_q), 2);
        check("raster_bad_total", run_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
